serial_mult_sched: RTL and testbench

- Shares one bit-serial multiplier between two parallel requesters.
- Arbitrates round-robin, serializes each accepted job onto the multiplier's 1-bit input as a framed bit stream, waits the fixed result latency, captures the 33-bit product and returns it with the requester ID.
- Sits between the parallel compute clients and the serial multiplier datapath, and owns that datapath's control and reset lines.

---
 rtl/serial_mult_pkg.sv | 22 ++
 rtl/serial_mult_sched_ser.sv | 36 +++
 rtl/serial_mult_sched.sv | 156 +++++++++++++++
 tb/tb_serial_mult_sched.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_mult_pkg.sv
// Shared types and frame constants for the serial multiplier scheduler.
package serial_mult_pkg;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_LEN_W    = 8;
  localparam int unsigned DEF_PROD_LAT = 2;

  localparam int unsigned START_CYC = 1;
  localparam int unsigned LEN_CYC   = DEF_LEN_W;
  localparam int unsigned OPND_CYC  = DEF_DATA_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_LEN,
    S_MPLR,
    S_MCND,
    S_WAIT,
    S_RESP
  } state_t;

endpackage

// File: rtl/serial_mult_sched_ser.sv
// Loadable LSB-first shift register with a per-segment bit counter.
module serial_mult_ser #(
  parameter int unsigned FRAME_W = 72,
  parameter int unsigned CNT_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [FRAME_W-1:0] load_data,
  input  logic               shift,
  input  logic [CNT_W-1:0]   seg_len,
  output logic               bit_out,
  output logic               seg_done
);

  logic [FRAME_W-1:0] sr_q;
  logic [CNT_W-1:0]   cnt_q;

  assign bit_out  = sr_q[0];
  assign seg_done = shift && (cnt_q == seg_len - 1'b1);

  // Counter clears on the last bit of each segment so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (load) begin
      sr_q  <= load_data;
      cnt_q <= '0;
    end else if (shift) begin
      sr_q  <= sr_q >> 1;
      cnt_q <= seg_done ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/serial_mult_sched.sv
// Round-robin scheduler sharing one bit-serial multiplier between two requesters.
module serial_mult_sched
  import serial_mult_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned LEN_W    = DEF_LEN_W,
  parameter int unsigned PROD_LAT = DEF_PROD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [LEN_W-1:0]  req0_len,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [LEN_W-1:0]  req1_len,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic              rsp_err,
  output logic [DATA_W:0]   rsp_prod,
  output logic              mult_rst,
  output logic              mult_ctrl,
  output logic              mult_in,
  input  logic [DATA_W:0]   mult_prod
);

  localparam int unsigned CNT_W   = $clog2(DATA_W + 1);
  localparam int unsigned FRAME_W = 2 * DATA_W + LEN_W;

  state_t state_q, state_d;

  logic              ptr_q;
  logic              id_q;
  logic              err_q;
  logic              mrst_q;
  logic [DATA_W:0]   prod_q;
  logic [3:0]        wcnt_q;

  logic              gnt_id;
  logic              accept;
  logic              sel_err;
  logic [LEN_W-1:0]  sel_len;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [DATA_W-1:0] mask;
  logic [CNT_W-1:0]  seg_len;
  logic              ser_shift;
  logic              ser_bit;
  logic              ser_done;
  logic              wait_last;

  always_comb begin
    gnt_id  = (req0_valid && req1_valid) ? ptr_q : req1_valid;
    accept  = (state_q == S_IDLE) && !rst && (req0_valid || req1_valid);
    sel_len = gnt_id ? req1_len : req0_len;
    sel_a   = gnt_id ? req1_a : req0_a;
    sel_b   = gnt_id ? req1_b : req0_b;
    mask    = ~({DATA_W{1'b1}} << sel_len);
    sel_err = (sel_len == '0) || (sel_len > LEN_W'(DATA_W));
  end

  assign req0_ready = accept && !gnt_id;
  assign req1_ready = accept && gnt_id;

  assign ser_shift = state_q inside {S_LEN, S_MPLR, S_MCND};
  assign seg_len   = (state_q == S_LEN) ? CNT_W'(LEN_W) : CNT_W'(DATA_W);
  assign wait_last = (wcnt_q == 4'(PROD_LAT - 1));

  serial_mult_ser #(
    .FRAME_W (FRAME_W),
    .CNT_W   (CNT_W)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_data ({sel_b, sel_a & mask, sel_len}),
    .shift     (ser_shift),
    .seg_len   (seg_len),
    .bit_out   (ser_bit),
    .seg_done  (ser_done)
  );

  // A rejected job still spends one cycle in START with the frame pulse
  // suppressed, so its error response appears two cycles after accept.
  always_comb begin
    state_d   = state_q;
    mult_ctrl = 1'b0;
    mult_in   = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_START;
      S_START: begin
        mult_ctrl = !err_q;
        state_d   = err_q ? S_RESP : S_LEN;
      end
      S_LEN: begin
        mult_in = ser_bit;
        if (ser_done) state_d = S_MPLR;
      end
      S_MPLR: begin
        mult_in = ser_bit;
        if (ser_done) state_d = S_MCND;
      end
      S_MCND: begin
        mult_in = ser_bit;
        if (ser_done) state_d = S_WAIT;
      end
      S_WAIT:  if (wait_last) state_d = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      mult_ctrl = 1'b0;
      mult_in   = 1'b0;
      rsp_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    mrst_q <= rst;
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      prod_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ptr_q  <= !gnt_id;
        id_q   <= gnt_id;
        err_q  <= sel_err;
        prod_q <= '0;
      end
      if (state_q == S_WAIT) begin
        wcnt_q <= wait_last ? '0 : wcnt_q + 4'd1;
        if (wait_last) prod_q <= mult_prod;
      end
    end
  end

  assign mult_rst = rst | mrst_q;
  assign rsp_id   = id_q;
  assign rsp_err  = err_q;
  assign rsp_prod = prod_q;

endmodule

// File: tb/tb_serial_mult_sched.sv
// Scoreboard bench for serial_mult_sched with a behavioural serial multiplier.
module tb_serial_mult_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0]  req0_len, req1_len;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [32:0] rsp_prod;
  logic        mult_rst, mult_ctrl, mult_in;
  logic [32:0] mult_prod;

  always #5 clk = ~clk;

  serial_mult_sched #(
    .DATA_W   (32),
    .LEN_W    (8),
    .PROD_LAT (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_len   (req0_len),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_len   (req1_len),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err),
    .rsp_prod   (rsp_prod),
    .mult_rst   (mult_rst),
    .mult_ctrl  (mult_ctrl),
    .mult_in    (mult_in),
    .mult_prod  (mult_prod)
  );

  typedef struct {
    logic [7:0]  len;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] am;
    logic [32:0] prod;
  } job_t;

  typedef struct {
    logic        id;
    logic        err;
    logic [32:0] prod;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [71:0] frame_q[$];
  job_t        j0[2];
  job_t        j1[2];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   hs_cyc = -100;
  int   ctrl_count = 0;
  int   mrst_cnt = 0;
  int   mrst_run = 0;
  int   m31_cyc = 0;
  logic m31_val = 1'b0;
  bit   busy = 1'b0;
  bit   chk_after_hs = 1'b0;
  bit   rsp_held = 1'b0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event (cycle %0d)", nm, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier: decodes the frame, product valid two cycles after the last bit.
  bit          coll = 1'b0;
  bit          pend = 1'b0;
  int          bi = 0;
  logic [71:0] fr;
  logic [63:0] full;
  always @(posedge clk) begin
    if (mult_rst) begin
      coll = 1'b0;
      pend = 1'b0;
      mult_prod <= '0;
    end else begin
      if (pend) begin
        mult_prod <= full[32:0];
        pend = 1'b0;
      end
      if (coll) begin
        fr[bi] = mult_in;
        if (bi == 39) begin
          m31_val = mult_in;
          m31_cyc = cyc;
        end
        bi++;
        if (bi == 72) begin
          coll = 1'b0;
          pend = 1'b1;
          full = 64'(fr[39:8]) * 64'(fr[71:40]);
          chk("frame_end", cyc - acc_cyc, 73);
          if (frame_q.size() == 0) timeout("frame_unexpected");
          else chk("frame", fr, frame_q.pop_front());
        end
      end else if (!mult_ctrl) begin
        chk("idle_in", mult_in, 0);
      end
      if (mult_ctrl) begin
        chk("start_bit", mult_in, 0);
        coll = 1'b1;
        bi = 0;
        mult_prod <= '0;
      end
    end
  end

  // Monitor: handshakes, timing and scoreboard comparison.
  always @(negedge clk) begin
    if (rst) busy = 1'b0;
    if (mult_rst) mrst_cnt++;
    else begin
      if (mrst_cnt != 0) mrst_run = mrst_cnt;
      mrst_cnt = 0;
    end
    if (req0_ready || req1_ready) begin
      chk("ready_idle", busy, 0);
      chk("ready_onehot", req0_ready & req1_ready, 0);
    end
    if ((req0_ready && req0_valid) || (req1_ready && req1_valid)) begin
      if (chk_after_hs) begin
        chk("acc_after_hs", cyc - hs_cyc, 1);
        chk_after_hs = 1'b0;
      end
      acc_cyc = cyc;
      busy = 1'b1;
    end
    if (mult_ctrl) begin
      ctrl_count++;
      chk("ctrl_cyc", cyc - acc_cyc, 1);
    end
    if (rsp_valid) begin
      if (sb.size() == 0) timeout("rsp_unexpected");
      else begin
        if (!rsp_held) chk("rsp_lat", cyc - acc_cyc, sb[0].lat);
        chk("rsp_id", rsp_id, sb[0].id);
        chk("rsp_err", rsp_err, sb[0].err);
        chk("rsp_prod", rsp_prod, sb[0].prod);
        if (rsp_ready) begin
          void'(sb.pop_front());
          hs_cyc = cyc;
          busy = 1'b0;
        end
      end
    end
    rsp_held = rsp_valid && !rsp_ready;
  end

  task automatic expect_job(input logic id, input job_t j, input logic err);
    exp_t e;
    e.id   = id;
    e.err  = err;
    e.prod = err ? 33'd0 : j.prod;
    e.lat  = err ? 2 : 76;
    sb.push_back(e);
    if (!err) frame_q.push_back({j.b, j.am, j.len});
  endtask

  task automatic set0(input job_t j);
    req0_len = j.len; req0_a = j.a; req0_b = j.b;
  endtask

  task automatic set1(input job_t j);
    req1_len = j.len; req1_a = j.a; req1_b = j.b;
  endtask

  task automatic drive_jobs(input int n0, input int n1);
    int k0 = 0;
    int k1 = 0;
    int guard = 0;
    if (n0 > 0) begin set0(j0[0]); req0_valid = 1'b1; end
    if (n1 > 0) begin set1(j1[0]); req1_valid = 1'b1; end
    while ((k0 < n0 || k1 < n1) && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (req0_valid && req0_ready) begin
        @(posedge clk); #1;
        k0++;
        if (k0 < n0) set0(j0[k0]); else req0_valid = 1'b0;
      end else if (req1_valid && req1_ready) begin
        @(posedge clk); #1;
        k1++;
        if (k1 < n1) set1(j1[k1]); else req1_valid = 1'b0;
      end
    end
    if (guard >= 3000) begin
      timeout("drive_accept");
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((sb.size() != 0 || busy) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) timeout("drain");
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int c;
    int guard;
    job_t x;
    rst = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_len = '0; req0_a = '0; req0_b = '0;
    req1_len = '0; req1_a = '0; req1_b = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {rsp_valid, req0_ready, req1_ready, mult_ctrl, mult_in, rsp_id, rsp_err, rsp_prod}, 0);
    chk("rst_mult_rst", mult_rst, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_hold", mult_rst, 1);
    @(negedge clk);
    chk("mrst_drop", mult_rst, 0);
    @(posedge clk); #1;

    // Single job
    j0[0] = '{8'd8, 32'h1FF, 32'd3, 32'hFF, 33'h2FD};
    expect_job(1'b0, j0[0], 1'b0);
    drive_jobs(1, 0);
    wait_drain();

    // Bad lengths
    c = ctrl_count;
    j1[0] = '{8'd0, 32'h5, 32'h7, 32'h0, 33'h0};
    expect_job(1'b1, j1[0], 1'b1);
    drive_jobs(0, 1);
    wait_drain();
    j1[0] = '{8'd33, 32'hFFFF, 32'h7, 32'h0, 33'h0};
    expect_job(1'b1, j1[0], 1'b1);
    drive_jobs(0, 1);
    wait_drain();
    chk("no_ctrl", ctrl_count, c);

    // Contention: grants must alternate 0,1,0,1
    j0[0] = '{8'd4,  32'hFF,       32'd5,        32'hF,        33'h4B};
    j1[0] = '{8'd16, 32'h12345678, 32'h10,       32'h5678,     33'h56780};
    j0[1] = '{8'd32, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33'h000000001};
    j1[1] = '{8'd1,  32'h3,        32'hABCDEF01, 32'h1,        33'h0ABCDEF01};
    expect_job(1'b0, j0[0], 1'b0);
    expect_job(1'b1, j1[0], 1'b0);
    expect_job(1'b0, j0[1], 1'b0);
    expect_job(1'b1, j1[1], 1'b0);
    drive_jobs(2, 2);
    wait_drain();

    // Backpressure with req0 pending; pending job is the full-width case
    j0[0] = '{8'd12, 32'hFFFFF123, 32'h100, 32'h123, 33'h12300};
    expect_job(1'b0, j0[0], 1'b0);
    drive_jobs(1, 0);
    x = '{8'd32, 32'h80000000, 32'd1, 32'h80000000, 33'h080000000};
    expect_job(1'b0, x, 1'b0);
    set0(x);
    req0_valid = 1'b1;
    rsp_ready = 1'b0;
    guard = 0;
    while (!rsp_valid && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) timeout("bp_rsp_valid");
    chk_after_hs = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_ready", req0_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    guard = 0;
    while (!req0_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) timeout("bp_accept");
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_drain();
    chk("m31_val", m31_val, 1);
    chk("m31_cyc", m31_cyc - acc_cyc, 41);

    // Reset mid-frame, then both requesters: pointer must favour req0 again
    x = '{8'd32, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33'h1FFFFFFFE};
    set0(x);
    req0_valid = 1'b1;
    guard = 0;
    while (!req0_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) timeout("mid_accept");
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_quiet", {mult_ctrl, mult_in, rsp_valid}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mrst_len", mrst_run, 2);
    @(posedge clk); #1;
    j0[0] = x;
    j1[0] = '{8'd2, 32'h3, 32'h7, 32'h3, 33'h15};
    expect_job(1'b0, j0[0], 1'b0);
    expect_job(1'b1, j1[0], 1'b0);
    drive_jobs(1, 1);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
